// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Definitions shared by the UART receiver and transmitter.
//               Holds the receiver FSM state encoding and the default frame
//               geometry (data bits per frame, clk cycles per bit period).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Default frame geometry.
    localparam int c_WORD_LENGHT_DEFAULT  = 8;
    localparam int c_CLKS_PER_BIT_DEFAULT = 16;

    // Receiver FSM states. The encoding is given explicitly so the state
    // register width is fixed and known.
    typedef enum logic [2:0] {
        WAIT_IDLE = 3'd0,
        IDLE      = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
        PARITY    = 3'd4,
        STOP      = 3'd5
    } uart_rx_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer for a single asynchronous level.
//               Both flops reset to 1 so an idle-high serial line does not
//               look like a start edge when reset is released.
// Ports       : clk  - clock
//               rst  - asynchronous active-high reset
//               i_d  - asynchronous input level
//               o_q  - input level synchronized to clk
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : UART receiver, LSB first, one stop bit. The serial line is
//               synchronized first, then a state machine finds the start bit,
//               samples every bit at mid-bit and reports one of: a good
//               word, a framing error or (optionally) a parity error.
// Config      : UART_RX_PARITY_EN - when defined, one even-parity bit follows
//               the data bits; otherwise Parity_err is tied to 0.
// Parameters  : WORD_LENGHT  - data bits per frame
//               CLKS_PER_BIT - clk cycles per bit period (even, >= 4)
// Ports       : clk        - clock
//               rst        - asynchronous active-high reset
//               Rx_in      - serial line, idles high, asynchronous to clk
//               Rx_out     - last correctly received word
//               Rx_valid   - one-cycle pulse when Rx_out is updated
//               Rx_busy    - high while a frame is in progress
//               Frame_err  - one-cycle pulse when the stop bit is sampled low
//               Parity_err - one-cycle pulse on a parity mismatch
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int WORD_LENGHT  = c_WORD_LENGHT_DEFAULT,
    parameter int CLKS_PER_BIT = c_CLKS_PER_BIT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   Rx_in,
    output logic [WORD_LENGHT-1:0] Rx_out,
    output logic                   Rx_valid,
    output logic                   Rx_busy,
    output logic                   Frame_err,
    output logic                   Parity_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(WORD_LENGHT + 1);

    // START waits half a bit so every later sample lands at mid-bit.
    localparam logic [CW-1:0] c_HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] c_FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] c_LAST    = BW'(WORD_LENGHT - 1);

    logic w_line;

    uart_rx_state_t r_state, w_state_nxt;
    logic [CW-1:0]          r_cnt,   w_cnt_nxt;
    logic [BW-1:0]          r_bit,   w_bit_nxt;
    logic [WORD_LENGHT-1:0] r_shift, w_shift_nxt;
    logic [WORD_LENGHT-1:0] r_out,   w_out_nxt;
    logic                   r_valid, w_valid_nxt;
    logic                   r_ferr,  w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
    logic                   r_pbad,  w_pbad_nxt;
    logic                   r_perr,  w_perr_nxt;
`endif

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (Rx_in),
        .o_q (w_line)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= WAIT_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_pbad  <= 1'b0;
            r_perr  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_out   <= w_out_nxt;
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
            r_pbad  <= w_pbad_nxt;
            r_perr  <= w_perr_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_out_nxt   = r_out;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_pbad_nxt  = r_pbad;
        w_perr_nxt  = 1'b0;
`endif
        case (r_state)
            // After a framing error the line may still be in a break; wait
            // for it to go high so the break is not taken as a start bit.
            WAIT_IDLE: begin
                w_cnt_nxt = '0;
                if (w_line) w_state_nxt = IDLE;
            end
            IDLE: begin
                w_cnt_nxt = '0;
                if (!w_line) w_state_nxt = START;
            end
            START: begin
                if (r_cnt == c_HALF_M1) begin
                    w_cnt_nxt = '0;
                    w_bit_nxt = '0;
                    // A line back high at mid start bit was only a glitch.
                    w_state_nxt = w_line ? IDLE : DATA;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            DATA: begin
                if (r_cnt == c_FULL_M1) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {w_line, r_shift[WORD_LENGHT-1:1]};
                    if (r_bit == c_LAST) begin
                        w_bit_nxt = '0;
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_state_nxt = STOP;
`endif
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (r_cnt == c_FULL_M1) begin
                    w_cnt_nxt = '0;
                    // Even parity: data bits plus parity bit XOR to zero.
                    w_pbad_nxt  = w_line ^ (^r_shift);
                    w_state_nxt = STOP;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
`endif
            STOP: begin
                if (r_cnt == c_FULL_M1) begin
                    w_cnt_nxt = '0;
                    if (w_line) begin
                        // Straight to IDLE so a start edge right after the
                        // stop sample is not missed.
                        w_state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (r_pbad) begin
                            w_perr_nxt = 1'b1;
                        end else begin
                            w_valid_nxt = 1'b1;
                            w_out_nxt   = r_shift;
                        end
`else
                        w_valid_nxt = 1'b1;
                        w_out_nxt   = r_shift;
`endif
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = WAIT_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = WAIT_IDLE;
            end
        endcase
    end

    assign Rx_out    = r_out;
    assign Rx_valid  = r_valid;
    assign Frame_err = r_ferr;
    assign Rx_busy   = (r_state == START) || (r_state == DATA) ||
                       (r_state == PARITY) || (r_state == STOP);
`ifdef UART_RX_PARITY_EN
    assign Parity_err = r_perr;
`else
    assign Parity_err = 1'b0;
`endif

endmodule : uart_rx
`default_nettype wire
